// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, ALU codes,
// datapath mux selects and opcodes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecuteR,
      StExecuteI, StAluWb, StBranch, StJal, StLui, StTrap
   } state_t;

   localparam logic [3:0] AluAnd   = 4'b0000;
   localparam logic [3:0] AluOr    = 4'b0001;
   localparam logic [3:0] AluAdd   = 4'b0010;
   localparam logic [3:0] AluXor   = 4'b0011;
   localparam logic [3:0] AluSll   = 4'b0100;
   localparam logic [3:0] AluSltu  = 4'b0101;
   localparam logic [3:0] AluSub   = 4'b0110;
   localparam logic [3:0] AluCmpU  = 4'b0111;
   localparam logic [3:0] AluSrl   = 4'b1000;
   localparam logic [3:0] AluPassB = 4'b1001;
   localparam logic [3:0] AluSlt   = 4'b1010;
   localparam logic [3:0] AluSra   = 4'b1100;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARegA  = 2'b10;

   localparam logic [1:0] SrcBRegB  = 2'b00;
   localparam logic [1:0] SrcBImm   = 2'b01;
   localparam logic [1:0] SrcBFour  = 2'b10;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResMemData   = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmJ = 3'b011;
   localparam logic [2:0] ImmU = 3'b100;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpLui    = 7'b0110111;

   function automatic logic [2:0] imm_src(input logic [6:0] op);
      case (op)
         OpStore:  return ImmS;
         OpBranch: return ImmB;
         OpJal:    return ImmJ;
         OpLui:    return ImmU;
         default:  return ImmI;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Function decode shared by R-type and I-type ALU instructions.
module alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [3:0] alu_code
);

   always_comb begin
      alu_code = AluAdd;
      case (funct3)
         3'b000:  alu_code = (is_rtype && funct7b5) ? AluSub : AluAdd;
         3'b001:  alu_code = AluSll;
         3'b010:  alu_code = AluSlt;
         3'b011:  alu_code = AluSltu;
         3'b100:  alu_code = AluXor;
         // srai carries instruction[30] too, so this applies to both formats
         3'b101:  alu_code = funct7b5 ? AluSra : AluSrl;
         3'b110:  alu_code = AluOr;
         default: alu_code = AluAnd;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the ALU code, datapath mux selects and write enables.
module mc_control_unit
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       Con_BLT,
   input  logic       Con_BGT,
   input  logic       mem_ready,
   output logic [3:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       illegal_instr
);

   state_t     state_q, state_d;
   logic [3:0] func_code;
   logic       taken;
   logic       unused_bgt;

   assign unused_bgt = Con_BGT;

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_rtype (op == OpRtype),
      .alu_code (func_code)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      ALUControl    = 4'b0000;
      ALUSrcA       = SrcAPc;
      ALUSrcB       = SrcBRegB;
      ResultSrc     = ResAluOut;
      ImmSrc        = imm_src(op);
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      illegal_instr = 1'b0;
      taken         = 1'b0;
      case (state_q)
         StFetch: begin
            ALUSrcB    = SrcBFour;
            ALUControl = AluAdd;
            ResultSrc  = ResAluResult;
            IRWrite    = mem_ready;
            PCWrite    = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            ALUSrcA    = SrcAOldPc;
            ALUSrcB    = SrcBImm;
            ALUControl = AluAdd;
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRtype:         state_d = StExecuteR;
               OpItype:         state_d = StExecuteI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpLui:           state_d = StLui;
               default:         state_d = StTrap;
            endcase
         end
         StMemAdr: begin
            ALUSrcA    = SrcARegA;
            ALUSrcB    = SrcBImm;
            ALUControl = AluAdd;
            state_d    = (op == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = ResMemData;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_d = StFetch;
         end
         StExecuteR: begin
            ALUSrcA    = SrcARegA;
            ALUSrcB    = SrcBRegB;
            ALUControl = func_code;
            state_d    = StAluWb;
         end
         StExecuteI: begin
            ALUSrcA    = SrcARegA;
            ALUSrcB    = SrcBImm;
            ALUControl = func_code;
            state_d    = StAluWb;
         end
         StAluWb: begin
            ResultSrc = ResAluOut;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            ALUSrcA    = SrcARegA;
            ALUSrcB    = SrcBRegB;
            ResultSrc  = ResAluOut;
            ALUControl = AluCmpU;
            state_d    = StFetch;
            case (funct3)
               3'b000: taken = zero;
               3'b001: taken = !zero;
               3'b100: begin ALUControl = AluSub; taken = Con_BLT;  end
               3'b101: begin ALUControl = AluSub; taken = !Con_BLT; end
               3'b110: taken = Con_BLT;
               3'b111: taken = !Con_BLT;
               default: state_d = StTrap;
            endcase
            PCWrite = taken;
         end
         StJal: begin
            ALUSrcA    = SrcAOldPc;
            ALUSrcB    = SrcBFour;
            ALUControl = AluAdd;
            ResultSrc  = ResAluOut;
            PCWrite    = 1'b1;
            state_d    = StAluWb;
         end
         StLui: begin
            ALUSrcB    = SrcBImm;
            ALUControl = AluPassB;
            ImmSrc     = ImmU;
            state_d    = StAluWb;
         end
         StTrap: illegal_instr = 1'b1;
         default: state_d = StFetch;
      endcase

      // Reset presents the FETCH selects with every enable suppressed
      if (reset) begin
         ALUControl    = AluAdd;
         ALUSrcA       = SrcAPc;
         ALUSrcB       = SrcBFour;
         ResultSrc     = ResAluResult;
         AdrSrc        = 1'b0;
         IRWrite       = 1'b0;
         PCWrite       = 1'b0;
         RegWrite      = 1'b0;
         MemWrite      = 1'b0;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle output signatures against hand-built
// expectations for each instruction class, stalls, traps and reset.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'b0;
   logic [2:0] funct3 = 3'b0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       Con_BLT = 1'b0;
   logic       Con_BGT = 1'b0;
   logic       mem_ready = 1'b1;
   logic [3:0] ALUControl;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ImmSrc;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr;

   int errors = 0;
   int checks = 0;

   mc_control_unit dut (
      .clk           (clk),
      .reset         (reset),
      .op            (op),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .zero          (zero),
      .Con_BLT       (Con_BLT),
      .Con_BGT       (Con_BGT),
      .mem_ready     (mem_ready),
      .ALUControl    (ALUControl),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .ResultSrc     (ResultSrc),
      .ImmSrc        (ImmSrc),
      .AdrSrc        (AdrSrc),
      .IRWrite       (IRWrite),
      .PCWrite       (PCWrite),
      .RegWrite      (RegWrite),
      .MemWrite      (MemWrite),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   // {ALUControl, SrcA, SrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal}
   logic [15:0] obs;
   assign obs = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
                 RegWrite, MemWrite, illegal_instr};

   function automatic logic [15:0] mk(input logic [3:0] a, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic adr, input logic ir, input logic pc,
                                      input logic rw, input logic mw, input logic ill);
      return {a, sa, sb, rs, adr, ir, pc, rw, mw, ill};
   endfunction

   localparam logic [15:0] FetchGo   = mk(4'b0010, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0);
   localparam logic [15:0] FetchWait = mk(4'b0010, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
   localparam logic [15:0] Decode    = mk(4'b0010, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
   localparam logic [15:0] AluWb     = mk(4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
   localparam logic [15:0] MemAdr    = mk(4'b0010, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
   localparam logic [15:0] MemRead   = mk(4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
   localparam logic [15:0] MemWb     = mk(4'b0000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0);
   localparam logic [15:0] MemWr     = mk(4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0);
   localparam logic [15:0] Trap      = mk(4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
   localparam logic [15:0] Jal       = mk(4'b0010, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0);
   localparam logic [15:0] Lui       = mk(4'b1001, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);

   // One clock: drive inputs after the falling edge, settle, then sample.
   task automatic cyc(input logic m);
      @(negedge clk);
      reset = 1'b0;
      mem_ready = m;
      #1;
   endtask

   // Reset for one edge, with mem_ready high to show enables stay suppressed.
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      if (obs !== FetchWait || illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL reset_%s: got %h want %h", tag, obs, FetchWait);
      end
      checks++;
   endtask

   task automatic test_reset();
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
      do_reset("init");
      cyc(1'b0);
      if (obs !== FetchWait) begin
         errors++;
         $display("FAIL reset_fetch_stall: got %h want %h", obs, FetchWait);
      end
      checks++;
   endtask

   task automatic test_addi();
      logic [15:0] e [5];
      e = '{FetchGo, Decode, mk(4'b0010, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), AluWb,
            FetchGo};
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      do_reset("addi");
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1);
         if (obs !== e[i]) begin
            errors++;
            $display("FAIL addi cyc%0d: got %h want %h", i, obs, e[i]);
         end
         checks++;
      end
      if (ImmSrc !== 3'b000) begin
         errors++;
         $display("FAIL addi_immsrc: got %b want 000", ImmSrc);
      end
      checks++;
   endtask

   task automatic test_lw_stall();
      logic [15:0] e [11];
      logic        m [11];
      int          ir_cnt;
      e = '{FetchWait, FetchWait, FetchGo, Decode, MemAdr, MemRead, MemRead, MemRead,
            MemRead, MemWb, FetchGo};
      m = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
      ir_cnt = 0;
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
      do_reset("lw");
      for (int i = 0; i < 11; i++) begin
         cyc(m[i]);
         if (i < 10 && IRWrite) ir_cnt++;
         if (obs !== e[i]) begin
            errors++;
            $display("FAIL lw cyc%0d: got %h want %h", i, obs, e[i]);
         end
         checks++;
      end
      if (ir_cnt !== 1) begin
         errors++;
         $display("FAIL lw_irwrite_pulses: got %0d want 1", ir_cnt);
      end
      checks++;
   endtask

   task automatic test_branch();
      logic [2:0]  f3 [3];
      logic        blt [3];
      logic        z [3];
      logic [15:0] br [3];
      f3  = '{3'b100, 3'b111, 3'b000};
      blt = '{1'b1, 1'b1, 1'b0};
      z   = '{1'b0, 1'b0, 1'b1};
      br  = '{mk(4'b0110, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0),
              mk(4'b0111, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0),
              mk(4'b0111, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0)};
      for (int k = 0; k < 3; k++) begin
         op = 7'b1100011; funct3 = f3[k]; Con_BLT = blt[k]; zero = z[k];
         do_reset("br");
         cyc(1'b1);
         cyc(1'b1);
         cyc(1'b0);
         if (obs !== br[k] || ImmSrc !== 3'b010) begin
            errors++;
            $display("FAIL branch%0d: got %h imm %b want %h imm 010", k, obs, ImmSrc, br[k]);
         end
         checks++;
         cyc(1'b1);
         if (obs !== FetchGo) begin
            errors++;
            $display("FAIL branch%0d_ret: got %h want %h", k, obs, FetchGo);
         end
         checks++;
      end
      Con_BLT = 1'b0; zero = 1'b0;
   endtask

   task automatic test_rtype();
      logic [2:0] f3 [3];
      logic       f7 [3];
      logic [3:0] c [3];
      f3 = '{3'b101, 3'b101, 3'b000};
      f7 = '{1'b1, 1'b0, 1'b1};
      c  = '{4'b1100, 4'b1000, 4'b0110};
      for (int k = 0; k < 3; k++) begin
         op = 7'b0110011; funct3 = f3[k]; funct7b5 = f7[k];
         do_reset("r");
         cyc(1'b1);
         cyc(1'b1);
         cyc(1'b1);
         if (obs !== mk(c[k], 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rtype%0d: got %h want code %b", k, obs, c[k]);
         end
         checks++;
         cyc(1'b1);
         if (obs !== AluWb) begin
            errors++;
            $display("FAIL rtype%0d_wb: got %h want %h", k, obs, AluWb);
         end
         checks++;
      end
   endtask

   task automatic test_trap();
      int bad;
      op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0;
      do_reset("trap");
      cyc(1'b1);
      cyc(1'b1);
      if (obs !== Decode || ImmSrc !== 3'b000) begin
         errors++;
         $display("FAIL trap_decode: got %h imm %b want %h imm 000", obs, ImmSrc, Decode);
      end
      checks++;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(i[0]);
         if (obs !== Trap) bad++;
      end
      if (bad !== 0) begin
         errors++;
         $display("FAIL trap_hold: got %0d bad cycles want 0 (last %h)", bad, obs);
      end
      checks++;
      do_reset("in_trap");
      cyc(1'b1);
      if (obs !== FetchGo) begin
         errors++;
         $display("FAIL trap_exit: got %h want %h", obs, FetchGo);
      end
      checks++;
   endtask

   task automatic test_sw_stall();
      int mw_run;
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
      do_reset("sw");
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      if (obs !== MemAdr || ImmSrc !== 3'b001) begin
         errors++;
         $display("FAIL sw_memadr: got %h imm %b want %h imm 001", obs, ImmSrc, MemAdr);
      end
      checks++;
      mw_run = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(i == 4);
         if (obs === MemWr) mw_run++;
      end
      cyc(1'b1);
      if (mw_run !== 5 || obs !== FetchGo) begin
         errors++;
         $display("FAIL sw_memwrite_run: got %0d then %h want 5 then %h", mw_run, obs, FetchGo);
      end
      checks++;
      // Second store, aborted by reset mid-stall
      do_reset("sw2");
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      if (obs !== MemWr) begin
         errors++;
         $display("FAIL sw_stall: got %h want %h", obs, MemWr);
      end
      checks++;
      do_reset("sw_abort");
      cyc(1'b0);
      if (obs !== FetchWait || MemWrite !== 1'b0) begin
         errors++;
         $display("FAIL sw_abort_fetch: got %h want %h", obs, FetchWait);
      end
      checks++;
   endtask

   task automatic test_jal_lui();
      op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
      do_reset("jal");
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b0);
      if (obs !== Jal || ImmSrc !== 3'b011) begin
         errors++;
         $display("FAIL jal: got %h imm %b want %h imm 011", obs, ImmSrc, Jal);
      end
      checks++;
      cyc(1'b0);
      if (obs !== AluWb) begin
         errors++;
         $display("FAIL jal_wb: got %h want %h", obs, AluWb);
      end
      checks++;
      op = 7'b0110111;
      do_reset("lui");
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      if (obs !== Lui || ImmSrc !== 3'b100) begin
         errors++;
         $display("FAIL lui: got %h imm %b want %h imm 100", obs, ImmSrc, Lui);
      end
      checks++;
      cyc(1'b1);
      if (obs !== AluWb) begin
         errors++;
         $display("FAIL lui_wb: got %h want %h", obs, AluWb);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw_stall();
      test_branch();
      test_rtype();
      test_trap();
      test_sw_stall();
      test_jal_lui();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
